// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: owns PC, issues one fetch per PC value, steps/jumps/pauses/stops.
// Latency: 2 cycles per instruction minimum (FETCH with immediate ack, then ADV); all outputs registered.
// Backpressure: FetchReq holds with PC stable until FetchAck; WAIT_MAX+1 unacked cycles -> ERR.
// Optional feature: define PC_FETCH_WRAP_EN to wrap PC to 0 after LAST_ADDR instead of stopping in DONE.
module pc_fetch_ctrl #(
  parameter int PC_W      = 4,
  parameter int LAST_ADDR = 15,
  parameter int WAIT_MAX  = 7
) (
  input  logic            MainClock,
  input  logic            ClearN,
  input  logic            Start,
  input  logic            Halt,
  input  logic            StepMode,
  input  logic            StepReq,
  input  logic            JumpEn,
  input  logic [PC_W-1:0] JumpAddr,
  input  logic            FetchAck,
  output logic            FetchReq,
  output logic [PC_W-1:0] PC,
  output logic            Running,
  output logic            Done,
  output logic            Timeout
);

  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(LAST_ADDR);
  localparam logic [7:0]      WAIT_LIM = 8'(WAIT_MAX);

  typedef enum logic [2:0] {
    sIdle,
    sFetch,
    sAdv,
    sPause,
    sDone,
    sErr
  } state_t;

  state_t          state;
  logic [7:0]      waitCnt;

  logic            atLast;
  logic            advStay;
  logic            advDone;
  logic [PC_W-1:0] advPc;
  logic            pauseGo;

  assign atLast  = (PC == LAST_PC);
  // Halt and StepMode are only honoured at the instruction boundary (ADV).
  assign advStay = Halt | StepMode;
  // A single step request wins over Start; otherwise Halt blocks Start.
  assign pauseGo = (StepMode & StepReq) | (Start & ~Halt);

`ifdef PC_FETCH_WRAP_EN
  // Jump beats the end-of-program wrap; the run never terminates.
  assign advPc   = JumpEn ? JumpAddr : (atLast ? '0 : PC + PC_W'(1));
  assign advDone = 1'b0;
`else
  // Jump beats the end-of-program stop; PC is left on LAST_ADDR when stopping.
  assign advPc   = JumpEn ? JumpAddr : (atLast ? PC : PC + PC_W'(1));
  assign advDone = ~JumpEn & atLast;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      state    <= sIdle;
      PC       <= '0;
      waitCnt  <= '0;
      FetchReq <= 1'b0;
      Running  <= 1'b0;
      Done     <= 1'b0;
      Timeout  <= 1'b0;
    end else begin
      case (state)
        sIdle: begin
          if (Start) begin
            state    <= sFetch;
            PC       <= '0;
            waitCnt  <= '0;
            FetchReq <= 1'b1;
            Running  <= 1'b1;
          end
        end

        sFetch: begin
          // An ack on the limit cycle still completes the fetch.
          if (FetchAck) begin
            state    <= sAdv;
            FetchReq <= 1'b0;
            waitCnt  <= '0;
          end else if (waitCnt == WAIT_LIM) begin
            state    <= sErr;
            FetchReq <= 1'b0;
            Running  <= 1'b0;
            Timeout  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end

        sAdv: begin
          PC <= advPc;
          if (advDone) begin
            state   <= sDone;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (advStay) begin
            state   <= sPause;
            Running <= 1'b0;
          end else begin
            state    <= sFetch;
            FetchReq <= 1'b1;
          end
        end

        sPause: begin
          if (pauseGo) begin
            state    <= sFetch;
            FetchReq <= 1'b1;
            Running  <= 1'b1;
          end
        end

        sDone: begin
          if (Start) begin
            state    <= sFetch;
            PC       <= '0;
            waitCnt  <= '0;
            Done     <= 1'b0;
            FetchReq <= 1'b1;
            Running  <= 1'b1;
          end
        end

        sErr: begin
          // Retry the same PC with a fresh wait budget.
          if (Start) begin
            state    <= sFetch;
            waitCnt  <= '0;
            Timeout  <= 1'b0;
            FetchReq <= 1'b1;
            Running  <= 1'b1;
          end
        end

        default: begin
          state    <= sIdle;
          FetchReq <= 1'b0;
          Running  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic       MainClock;
  logic       ClearN;
  logic       Start;
  logic       Halt;
  logic       StepMode;
  logic       StepReq;
  logic       JumpEn;
  logic [3:0] JumpAddr;
  logic       FetchAck;
  logic       FetchReq;
  logic [3:0] PC;
  logic       Running;
  logic       Done;
  logic       Timeout;

  int errCnt = 0;
  int chkCnt = 0;

  pc_fetch_ctrl #(.PC_W(4), .LAST_ADDR(15), .WAIT_MAX(7)) dut (
    .MainClock(MainClock),
    .ClearN(ClearN),
    .Start(Start),
    .Halt(Halt),
    .StepMode(StepMode),
    .StepReq(StepReq),
    .JumpEn(JumpEn),
    .JumpAddr(JumpAddr),
    .FetchAck(FetchAck),
    .FetchReq(FetchReq),
    .PC(PC),
    .Running(Running),
    .Done(Done),
    .Timeout(Timeout)
  );

  initial MainClock = 1'b0;
  always #5 MainClock = ~MainClock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge MainClock);
    #1;
  endtask

  task automatic doReset();
    ClearN = 1'b0;
    #7;
    ClearN = 1'b1;
    tick();
  endtask

  // Reset, then pulse Start: returns in FETCH at PC=0.
  task automatic startRun();
    doReset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // From FETCH at PC=p with ack held high, move on n instructions.
  task automatic runFor(input int n);
    FetchAck = 1'b1;
    for (int k = 0; k < 2 * n; k++) tick();
  endtask

  initial begin
    ClearN   = 1'b0;
    Start    = 1'b0;
    Halt     = 1'b0;
    StepMode = 1'b0;
    StepReq  = 1'b0;
    JumpEn   = 1'b0;
    JumpAddr = 4'd0;
    FetchAck = 1'b1;

    // Reset state, and IDLE ignores FetchAck without Start.
    #3;
    checkVal("rst_pc", 8'(PC), 8'd0);
    checkVal("rst_req", 8'(FetchReq), 8'd0);
    checkVal("rst_run", 8'(Running), 8'd0);
    checkVal("rst_done", 8'(Done), 8'd0);
    checkVal("rst_tmo", 8'(Timeout), 8'd0);
    ClearN = 1'b1;
    tick();
    tick();
    checkVal("idle_req", 8'(FetchReq), 8'd0);

    // Full run with immediate ack: 16 FETCH/ADV pairs, then DONE.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkVal($sformatf("run_pc%0d", i), 8'(PC), 8'(i));
      checkVal($sformatf("run_req%0d", i), 8'(FetchReq), 8'd1);
      tick();
      checkVal($sformatf("adv_req%0d", i), 8'(FetchReq), 8'd0);
      checkVal($sformatf("adv_run%0d", i), 8'(Running), 8'd1);
      tick();
    end
`ifdef PC_FETCH_WRAP_EN
    checkVal("wrap_pc", 8'(PC), 8'd0);
    checkVal("wrap_req", 8'(FetchReq), 8'd1);
    checkVal("wrap_done", 8'(Done), 8'd0);
`else
    checkVal("end_done", 8'(Done), 8'd1);
    checkVal("end_pc", 8'(PC), 8'd15);
    checkVal("end_run", 8'(Running), 8'd0);
    checkVal("end_req", 8'(FetchReq), 8'd0);
    // Restart from DONE goes back to PC=0.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checkVal("restart_pc", 8'(PC), 8'd0);
    checkVal("restart_done", 8'(Done), 8'd0);
    checkVal("restart_req", 8'(FetchReq), 8'd1);
`endif

    // Ack delayed 3 cycles at PC=2: FetchReq held 4 cycles with PC stable.
    startRun();
    runFor(2);
    FetchAck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkVal($sformatf("slow_req%0d", k), 8'(FetchReq), 8'd1);
      checkVal($sformatf("slow_pc%0d", k), 8'(PC), 8'd2);
      tick();
    end
    FetchAck = 1'b1;
    checkVal("slow_req3", 8'(FetchReq), 8'd1);
    checkVal("slow_pc3", 8'(PC), 8'd2);
    tick();
    tick();
    checkVal("slow_next_pc", 8'(PC), 8'd3);
    checkVal("slow_tmo", 8'(Timeout), 8'd0);

    // No ack at PC=5: timeout after 8 FETCH cycles, then retry same PC.
    startRun();
    runFor(5);
    FetchAck = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checkVal("tmo_pre", 8'(Timeout), 8'd0);
    checkVal("tmo_pre_req", 8'(FetchReq), 8'd1);
    tick();
    checkVal("tmo_flag", 8'(Timeout), 8'd1);
    checkVal("tmo_req", 8'(FetchReq), 8'd0);
    checkVal("tmo_pc", 8'(PC), 8'd5);
    checkVal("tmo_run", 8'(Running), 8'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checkVal("retry_req", 8'(FetchReq), 8'd1);
    checkVal("retry_pc", 8'(PC), 8'd5);
    checkVal("retry_tmo", 8'(Timeout), 8'd0);
    // Counter was cleared: ack arriving on the limit cycle completes normally.
    for (int k = 0; k < 7; k++) tick();
    FetchAck = 1'b1;
    tick();
    checkVal("limit_ack_tmo", 8'(Timeout), 8'd0);
    checkVal("limit_ack_run", 8'(Running), 8'd1);
    tick();
    checkVal("limit_ack_pc", 8'(PC), 8'd6);

    // Jump from PC=3 to 12, then a jump on the last address beats DONE.
    startRun();
    runFor(3);
    tick();
    JumpEn   = 1'b1;
    JumpAddr = 4'd12;
    tick();
    JumpEn   = 1'b0;
    checkVal("jmp_pc", 8'(PC), 8'd12);
    checkVal("jmp_req", 8'(FetchReq), 8'd1);
    runFor(3);
    checkVal("jmp_at15", 8'(PC), 8'd15);
    tick();
    JumpEn   = 1'b1;
    JumpAddr = 4'd4;
    tick();
    JumpEn   = 1'b0;
    checkVal("jmp_last_pc", 8'(PC), 8'd4);
    checkVal("jmp_last_done", 8'(Done), 8'd0);
    checkVal("jmp_last_req", 8'(FetchReq), 8'd1);

    // Step mode: pause after each instruction, one instruction per StepReq.
    StepMode = 1'b1;
    startRun();
    tick();
    tick();
    checkVal("step_pause_pc", 8'(PC), 8'd1);
    checkVal("step_pause_req", 8'(FetchReq), 8'd0);
    checkVal("step_pause_run", 8'(Running), 8'd0);
    tick();
    tick();
    checkVal("step_hold_pc", 8'(PC), 8'd1);
    StepReq = 1'b1;
    tick();
    StepReq = 1'b0;
    checkVal("step_fetch_pc", 8'(PC), 8'd1);
    checkVal("step_fetch_req", 8'(FetchReq), 8'd1);
    tick();
    tick();
    checkVal("step_next_pc", 8'(PC), 8'd2);
    checkVal("step_next_req", 8'(FetchReq), 8'd0);
    StepMode = 1'b0;

    // Halt raised during FETCH at PC=7 completes the instruction and pauses at PC=8.
    startRun();
    runFor(7);
    Halt = 1'b1;
    tick();
    tick();
    checkVal("halt_pc", 8'(PC), 8'd8);
    checkVal("halt_run", 8'(Running), 8'd0);
    Start = 1'b1;
    tick();
    checkVal("halt_dom_req", 8'(FetchReq), 8'd0);
    Halt = 1'b0;
    tick();
    Start = 1'b0;
    checkVal("resume_req", 8'(FetchReq), 8'd1);
    checkVal("resume_pc", 8'(PC), 8'd8);

    // Asynchronous clear in the middle of FETCH at PC=9.
    tick();
    tick();
    checkVal("pre_clr_pc", 8'(PC), 8'd9);
    #3;
    ClearN = 1'b0;
    #1;
    checkVal("clr_req", 8'(FetchReq), 8'd0);
    checkVal("clr_pc", 8'(PC), 8'd0);
    checkVal("clr_run", 8'(Running), 8'd0);
    ClearN = 1'b1;
    tick();
    checkVal("clr_idle_req", 8'(FetchReq), 8'd0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequencing controller for the 4-bit program counter: owns the PC register and decides when it advances, jumps, pauses or stops.
- Issues one fetch request per PC value and waits for a memory acknowledge, with a timeout.
- Supports run, halt and single-step modes.
- Sits between the main clock/clear network and instruction memory. It replaces the free-running EnableCount gating of the ripple counter with a synchronous, handshaked sequence.

Parameters:
- PC_W, 4, width of PC and JumpAddr.
- LAST_ADDR, 15, final program address; reaching it ends the run (or wraps, see Optional Feature).
- WAIT_MAX, 7, maximum cycles FetchReq may stay unacknowledged before timeout; 1..255.

Ports:
- MainClock  in  1  system clock, rising edge.
- ClearN  in  1  asynchronous active-low reset.
- Start  in  1  begin/resume/retry request, level sampled.
- Halt  in  1  pause request, honoured only at instruction boundary.
- StepMode  in  1  1 = pause after every instruction.
- StepReq  in  1  execute one instruction while paused in step mode.
- JumpEn  in  1  load JumpAddr instead of incrementing, sampled in ADV.
- JumpAddr  in  PC_W  jump target.
- FetchAck  in  1  memory has accepted/returned the word at PC.
- FetchReq  out  1  fetch request; PC valid while high.
- PC  out  PC_W  current program counter.
- Running  out  1  high in FETCH and ADV.
- Done  out  1  high in DONE.
- Timeout  out  1  high in ERR.

Behaviour:
- Reset: async on ClearN=0. State=IDLE, PC=0, FetchReq=0, Running=0, Done=0, Timeout=0, wait counter=0. Reset mid-fetch drops FetchReq immediately, with no completion.
- All outputs are registered; all state changes occur on the MainClock rising edge.
- IDLE: Start=1 -> FETCH, PC=0.
- FETCH: FetchReq=1, PC held stable.
  - FetchAck=1 -> ADV, wait counter cleared.
  - Else wait counter +1. If the counter already equals WAIT_MAX -> ERR.
  - Ack in the same cycle as the counter limit wins and goes to ADV.
- ADV (one cycle, FetchReq=0), next-PC priority:
  - JumpEn=1 -> PC=JumpAddr.
  - Else PC==LAST_ADDR -> DONE, PC unchanged.
  - Else PC=PC+1.
- ADV next state, unless going to DONE: Halt=1 or StepMode=1 -> PAUSE; else FETCH.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ack, then ADV).
- PAUSE: FetchReq=0, Running=0.
  - StepMode=1 and StepReq=1 -> FETCH, one instruction.
  - Else Start=1 and Halt=0 -> FETCH.
  - Halt=1 dominates Start.
- DONE: Done=1. Start=1 -> FETCH with PC=0 and Done cleared.
- ERR: Timeout=1. Start=1 -> FETCH retrying the same PC, with Timeout and counter cleared.
- A jump taken on the LAST_ADDR cycle takes priority; no DONE.
- JumpAddr wider than PC_W is not possible; all PC arithmetic is modulo 2^PC_W.
- FetchAck outside FETCH is ignored.

Optional Feature:
- Macro PC_FETCH_WRAP_EN.
- Defined: in ADV with PC==LAST_ADDR and no jump, PC=0 and the run continues (FETCH or PAUSE per Halt/StepMode). DONE is unreachable and Done is tied 0.
- Undefined: behaviour as above; LAST_ADDR terminates the run in DONE.

Test Plan:
- Reset then Start=1, FetchAck always 1 -> PC 0,1,...,15, each held in FETCH 1 cycle then ADV. After PC=15 the ADV goes to DONE: Done=1, PC=15, 32 cycles after Start.
- FetchAck delayed 3 cycles at PC=2 -> FetchReq high 4 cycles with PC=2 stable, then PC=3. No Timeout.
- FetchAck held 0 at PC=5, WAIT_MAX=7 -> Timeout=1 after 8 FETCH cycles. Start -> FetchReq re-asserted with PC=5.
- JumpEn=1, JumpAddr=12 in the ADV after PC=3 -> next FETCH at PC=12. JumpAddr=4 on the PC=15 ADV -> PC=4, Done stays 0.
- StepMode=1 -> PAUSE after each instruction. Each StepReq pulse advances PC by exactly 1. Halt=1 during FETCH at PC=7 -> completes PC=7, pauses with PC=8. Start with Halt=0 resumes.
- ClearN pulsed low during FETCH at PC=9 -> FetchReq=0 and PC=0 asynchronously. With PC_FETCH_WRAP_EN defined, PC=15 is followed by PC=0 and Done is never asserted.
